// File: rtl/cu_fsm_pkg.sv
// Shared types and constants for the cu_fsm_ws multicycle control unit.
// ST_INTR exists only when CU_FSM_WS_INTR_EN is defined.
package cu_fsm_pkg;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int N_INTR_MIN  = 1;
  localparam int N_INTR_MAX  = 8;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_MRET = 3'b000;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_EXEC,
    ST_WB
`ifdef CU_FSM_WS_INTR_EN
    , ST_INTR
`endif
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic reg_write;
    logic mem_we2;
    logic mem_rden1;
    logic mem_rden2;
    logic csr_we;
    logic mret_exec;
  } ctrl_t;

endpackage

// File: rtl/cu_fsm_ws_intr_arb.sv
// Interrupt arbiter: rising-edge detection, sticky pending bits and a
// fixed-priority (lowest index wins) encoder. Synchronous active-high reset.
module intr_arb #(
  parameter int N_INTR = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [N_INTR-1:0]                           intr,
  input  logic                                        clr,
  input  logic [((N_INTR > 1) ? $clog2(N_INTR) : 1)-1:0] clr_id,
  output logic                                        any_pending,
  output logic [((N_INTR > 1) ? $clog2(N_INTR) : 1)-1:0] win_id
);

  localparam int ID_W = (N_INTR > 1) ? $clog2(N_INTR) : 1;

  logic [N_INTR-1:0] intr_q;
  logic [N_INTR-1:0] pending_q;
  logic [N_INTR-1:0] rise;
  logic [N_INTR-1:0] clr_mask;

  assign rise        = intr & ~intr_q;
  assign any_pending = |pending_q;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N_INTR; i++) begin
      clr_mask[i] = clr && (clr_id == ID_W'(i));
    end
  end

  // Scan from the top down so the lowest pending index is the last one written.
  always_comb begin
    win_id = '0;
    for (int i = N_INTR - 1; i >= 0; i--) begin
      if (pending_q[i]) win_id = ID_W'(i);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      intr_q    <= '0;
      pending_q <= '0;
    end else begin
      intr_q    <= intr;
      // A fresh edge on a line being cleared this cycle keeps it pending.
      pending_q <= (pending_q & ~clr_mask) | rise;
    end
  end

endmodule

// File: rtl/cu_fsm_ws.sv
// Multicycle control FSM (fetch / exec / writeback) with optional interrupt
// entry, compiled in only when CU_FSM_WS_INTR_EN is defined.
module cu_fsm_ws
  import cu_fsm_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int N_INTR  = 1
) (
  input  logic                                        CLK,
  input  logic                                        RST,
  input  logic [N_INTR-1:0]                           INTR,
  input  logic                                        mie,
  input  logic [6:0]                                  opcode,
  input  logic [2:0]                                  func3,
  output logic                                        PCWrite,
  output logic                                        regWrite,
  output logic                                        memWE2,
  output logic                                        memRDEN1,
  output logic                                        memRDEN2,
  output logic                                        csr_WE,
  output logic                                        mret_exec,
  output logic                                        int_taken,
  output logic [((N_INTR > 1) ? $clog2(N_INTR) : 1)-1:0] intr_id
);

  localparam int ID_W  = (N_INTR > 1) ? $clog2(N_INTR) : 1;
  localparam int CNT_W = $clog2(MEM_LAT_MAX);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_LAT - 1);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
    $error("cu_fsm_ws: MEM_LAT outside legal range");
  end
  if (N_INTR < N_INTR_MIN || N_INTR > N_INTR_MAX) begin : g_bad_n_intr
    $error("cu_fsm_ws: N_INTR outside legal range");
  end

  state_t           state_q, state_d, next_instr;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             last_wait;
  ctrl_t            ctrl, ctrl_o;

  assign last_wait = (wait_q == LAST_WAIT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctrl    = '0;
    unique case (state_q)
      ST_FETCH: begin
        ctrl.mem_rden1 = 1'b1;
        if (last_wait) begin
          wait_d  = '0;
          state_d = ST_EXEC;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_EXEC: begin
        ctrl.pc_write = 1'b1;
        state_d       = next_instr;
        case (opcode)
          OPC_LOAD: begin
            ctrl.pc_write  = 1'b0;
            ctrl.mem_rden2 = 1'b1;
            state_d        = ST_WB;
          end
          OPC_STORE: ctrl.mem_we2 = 1'b1;
          OPC_BRANCH: ;
          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM:
            ctrl.reg_write = 1'b1;
          OPC_SYSTEM: begin
            if (func3 == F3_MRET) begin
              ctrl.mret_exec = 1'b1;
            end else begin
              ctrl.csr_we    = 1'b1;
              ctrl.reg_write = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_WB: begin
        if (last_wait) begin
          ctrl.reg_write = 1'b1;
          ctrl.pc_write  = 1'b1;
          wait_d         = '0;
          state_d        = next_instr;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
`ifdef CU_FSM_WS_INTR_EN
      ST_INTR: begin
        ctrl.pc_write = 1'b1;
        state_d       = ST_FETCH;
      end
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset forces every strobe low combinationally, even mid-instruction.
  assign ctrl_o    = RST ? '0 : ctrl;
  assign PCWrite   = ctrl_o.pc_write;
  assign regWrite  = ctrl_o.reg_write;
  assign memWE2    = ctrl_o.mem_we2;
  assign memRDEN1  = ctrl_o.mem_rden1;
  assign memRDEN2  = ctrl_o.mem_rden2;
  assign csr_WE    = ctrl_o.csr_we;
  assign mret_exec = ctrl_o.mret_exec;

`ifdef CU_FSM_WS_INTR_EN
  logic            any_pending;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] intr_id_q;

  intr_arb #(.N_INTR(N_INTR)) u_intr_arb (
    .clk         (CLK),
    .rst         (RST),
    .intr        (INTR),
    .clr         (state_q == ST_INTR),
    .clr_id      (intr_id_q),
    .any_pending (any_pending),
    .win_id      (win_id)
  );

  assign next_instr = (mie && any_pending) ? ST_INTR : ST_FETCH;

  // Only ST_EXEC/ST_WB can select ST_INTR, so this captures the winner on entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      intr_id_q <= '0;
    end else if (state_d == ST_INTR) begin
      intr_id_q <= win_id;
    end
  end

  assign int_taken = !RST && (state_q == ST_INTR);
  assign intr_id   = int_taken ? intr_id_q : '0;
`else
  logic unused_intr;
  assign unused_intr = ^{INTR, mie};
  assign next_instr  = ST_FETCH;
  assign int_taken   = 1'b0;
  assign intr_id     = '0;
`endif

endmodule

// File: tb/tb_cu_fsm_ws.sv
// Self-checking bench for cu_fsm_ws: two instances (MEM_LAT=1 and 3, N_INTR=4)
// checked cycle by cycle against a per-instruction schedule model.
module tb_cu_fsm_ws;

  localparam int NI = 4;
`ifdef CU_FSM_WS_INTR_EN
  localparam bit INTR_ON = 1'b1;
`else
  localparam bit INTR_ON = 1'b0;
`endif

  // Observation vector bit positions; [1:0] carries intr_id.
  localparam int B_PC = 9, B_RW = 8, B_WE = 7, B_RD1 = 6, B_RD2 = 5;
  localparam int B_CSR = 4, B_MRET = 3, B_INT = 2;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011;
  localparam logic [6:0] OP = 7'b0110011, SYSTEM = 7'b1110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst  [2];
  logic [NI-1:0] intr [2];
  logic          mie  [2];
  logic [6:0]    opc  [2];
  logic [2:0]    f3   [2];
  logic [9:0]    obs  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pcw, rw, we2, rd1, rd2, csr, mret, itk;
    logic [1:0] id;
    cu_fsm_ws #(.MEM_LAT(g == 0 ? 1 : 3), .N_INTR(NI)) dut (
      .CLK       (clk),
      .RST       (rst[g]),
      .INTR      (intr[g]),
      .mie       (mie[g]),
      .opcode    (opc[g]),
      .func3     (f3[g]),
      .PCWrite   (pcw),
      .regWrite  (rw),
      .memWE2    (we2),
      .memRDEN1  (rd1),
      .memRDEN2  (rd2),
      .csr_WE    (csr),
      .mret_exec (mret),
      .int_taken (itk),
      .intr_id   (id)
    );
    assign obs[g] = {pcw, rw, we2, rd1, rd2, csr, mret, itk, id};
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: pending-interrupt mask and last sampled request lines.
  logic [NI-1:0] m_pend [2];
  logic [NI-1:0] m_prev [2];

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (pc rw we2 rd1 rd2 csr mret int id[1:0])", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs applied: check, then advance one clock.
  task automatic tick(input int d, input logic [9:0] exp, input logic [NI-1:0] clr, input string tag);
    #1 check(tag, obs[d], exp);
    @(posedge clk);
    if (rst[d]) begin
      m_pend[d] = '0;
      m_prev[d] = '0;
    end else begin
      m_pend[d] = (m_pend[d] & ~clr) | (intr[d] & ~m_prev[d]);
      m_prev[d] = intr[d];
    end
    @(negedge clk);
  endtask

  function automatic logic [9:0] exec_vec(input logic [6:0] op, input logic [2:0] fn);
    logic [9:0] v;
    v       = '0;
    v[B_PC] = 1'b1;
    case (op)
      7'b0000011: begin v[B_PC] = 1'b0; v[B_RD2] = 1'b1; end
      7'b0100011: v[B_WE] = 1'b1;
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0110011, 7'b0010011:
        v[B_RW] = 1'b1;
      7'b1110011: begin
        if (fn == 3'b000) v[B_MRET] = 1'b1;
        else begin v[B_CSR] = 1'b1; v[B_RW] = 1'b1; end
      end
      default: ;
    endcase
    return v;
  endfunction

  // One instruction: L fetch cycles, one exec cycle, L writeback cycles for a
  // load, then an interrupt-entry cycle if one is pending and enabled at the end.
  task automatic run_instr(input int d, input logic [6:0] op, input logic [2:0] fn,
                           input bit rnd, input int abort_at, input string tag);
    int         lat;
    int         n;
    logic [9:0] e;
    logic       take;
    logic [1:0] id;
    lat  = (d == 0) ? 1 : 3;
    n    = (op == LOAD) ? 2 * lat + 1 : lat + 1;
    take = 1'b0;
    id   = '0;
    opc[d] = op;
    f3[d]  = fn;
    for (int c = 0; c < n; c++) begin
      if (rnd && $urandom_range(0, 3) == 0) intr[d] = 4'($urandom);
      e = '0;
      if (c < lat) e[B_RD1] = 1'b1;
      else if (c == lat) e = exec_vec(op, fn);
      else if (c == 2 * lat) begin e[B_PC] = 1'b1; e[B_RW] = 1'b1; end
      if (c == abort_at) begin
        rst[d]  = 1'b1;
        intr[d] = '0;
        tick(d, '0, '0, {tag, "_rst"});
        rst[d] = 1'b0;
        return;
      end
      if (c == n - 1) begin
        take = INTR_ON && mie[d] && (m_pend[d] != '0);
        for (int i = NI - 1; i >= 0; i--) if (m_pend[d][i]) id = 2'(i);
      end
      tick(d, e, '0, tag);
    end
    if (take) begin
      e = '0;
      e[B_PC]  = 1'b1;
      e[B_INT] = 1'b1;
      e[1:0]   = id;
      tick(d, e, 4'(1) << id, {tag, "_intr"});
    end
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] tbl [10];
    tbl = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
            7'b1101111, 7'b1100111, 7'b0110011, 7'b0010011, 7'b1110011};
    if ($urandom_range(0, 9) == 0) return 7'($urandom);
    return tbl[$urandom_range(0, 9)];
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; intr[d] = '0; mie[d] = 1'b0; opc[d] = '0; f3[d] = '0;
      m_pend[d] = '0; m_prev[d] = '0;
    end
    @(negedge clk);

    // Instance 0: MEM_LAT=1
    for (int i = 0; i < 3; i++) begin
      opc[0] = rand_op(); intr[0] = 4'($urandom); mie[0] = 1'b1;
      tick(0, '0, '0, "reset0");
    end
    rst[0] = 1'b0; intr[0] = '0; mie[0] = 1'b1;
    run_instr(0, OP, 3'd0, 1'b0, -1, "op_a");
    run_instr(0, OP, 3'd0, 1'b0, -1, "op_b");

    intr[0] = 4'b1010;
    run_instr(0, STORE, 3'd0, 1'b0, -1, "store_intr");
    run_instr(0, OP, 3'd0, 1'b0, -1, "second_intr");
    run_instr(0, OP, 3'd0, 1'b0, -1, "quiet");

    intr[0] = '0; mie[0] = 1'b0;
    run_instr(0, OP, 3'd0, 1'b0, -1, "mie0_idle");
    intr[0] = 4'b0001;
    run_instr(0, BRANCH, 3'd0, 1'b0, -1, "mie0_edge");
    mie[0] = 1'b1;
    run_instr(0, OP, 3'd0, 1'b0, -1, "mie1_take");

    run_instr(0, SYSTEM, 3'b000, 1'b0, -1, "mret");
    run_instr(0, SYSTEM, 3'b001, 1'b0, -1, "csrrw");

    for (int k = 0; k < 150; k++) begin
      mie[0] = 1'($urandom_range(0, 1));
      run_instr(0, rand_op(), 3'($urandom), 1'b1, -1, "rand0");
    end
    rst[0] = 1'b1;
    tick(0, '0, '0, "park0");

    // Instance 1: MEM_LAT=3
    for (int i = 0; i < 2; i++) begin
      opc[1] = LOAD; mie[1] = 1'b1;
      tick(1, '0, '0, "reset1");
    end
    rst[1] = 1'b0; intr[1] = '0; mie[1] = 1'b1;
    run_instr(1, LOAD, 3'd0, 1'b0, -1, "load3");

    mie[1] = 1'b0; intr[1] = 4'b0100;
    run_instr(1, LOAD, 3'd0, 1'b0, 5, "load_wb2");
    mie[1] = 1'b1;
    run_instr(1, OP, 3'd0, 1'b0, -1, "post_rst");

    for (int k = 0; k < 80; k++) begin
      mie[1] = 1'($urandom_range(0, 1));
      run_instr(1, rand_op(), 3'($urandom), 1'b1, -1, "rand1");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cu_fsm_ws.md
CU_FSM_WS -- requirements
Module: cu_fsm_ws

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1: memory read latency in cycles for fetch and load, legal range 1..4.
REQ-002 SHALL have parameter N_INTR, default 1: number of interrupt request lines, legal range 1..8.
REQ-003 SHALL have port CLK, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port INTR, input, N_INTR bits: interrupt requests, edge-detected.
REQ-006 SHALL have port mie, input, 1 bit: global interrupt enable from the CSR unit.
REQ-007 SHALL have port opcode, input, 7 bits: IR[6:0].
REQ-008 SHALL have port func3, input, 3 bits: IR[14:12].
REQ-009 SHALL have outputs PCWrite, regWrite, memWE2, memRDEN1 and memRDEN2, each 1 bit, with the same meanings as in the existing multicycle control path.
REQ-010 SHALL have output csr_WE, 1 bit: CSR write strobe.
REQ-011 SHALL have output mret_exec, 1 bit: MRET executes this cycle.
REQ-012 SHALL have output int_taken, 1 bit: interrupt entry this cycle.
REQ-013 SHALL have output intr_id, width max(1,$clog2(N_INTR)): index of the interrupt being taken, valid while int_taken=1.

Function
REQ-014 SHALL implement four states: ST_FETCH, ST_EXEC, ST_WB and ST_INTR.
REQ-015 SHALL hold memRDEN1=1 in ST_FETCH for exactly MEM_LAT cycles, counted by a wait counter from 0 to MEM_LAT-1, then go to ST_EXEC.
REQ-016 SHALL, in ST_EXEC, assert outputs according to opcode:
- LOAD (0000011): memRDEN2=1, next state ST_WB, no PCWrite.
- STORE (0100011): memWE2=1, PCWrite=1.
- BRANCH (1100011): PCWrite=1.
- LUI, AUIPC, JAL, JALR, OP, OP_IMM: regWrite=1, PCWrite=1.
- SYSTEM (1110011) with func3=000: mret_exec=1, PCWrite=1.
- SYSTEM with any other func3: csr_WE=1, regWrite=1, PCWrite=1.
- Any other opcode: PCWrite=1 only (executed as a NOP).
REQ-017 SHALL wait MEM_LAT cycles in ST_WB and assert regWrite=1 and PCWrite=1 on the final cycle only.
REQ-018 SHALL, on leaving ST_EXEC (any non-LOAD) or ST_WB, go to ST_INTR if mie=1 and any interrupt is pending, else to ST_FETCH.
REQ-019 SHALL, in ST_INTR, assert int_taken=1 and PCWrite=1 for one cycle, clear the pending bit for intr_id, then go to ST_FETCH.
REQ-020 SHALL set a pending bit on each 0->1 transition of INTR[i]; a level held high SHALL NOT re-pend the line.
REQ-021 SHALL resolve pending interrupts by fixed priority, lowest index winning; intr_id SHALL be registered on entry to ST_INTR.
REQ-022 SHALL give set priority over clear when a new edge arrives on a line in the same cycle that line is cleared, so the line stays pending.
REQ-023 SHALL retain pending bits unchanged while mie=0.
REQ-024 SHALL never assert memWE2 together with memRDEN2, and SHALL assert PCWrite at most once per instruction.

Reset
REQ-025 SHALL, while RST=1 at a clock edge, drive state to ST_FETCH, clear the wait counter, pending bits and INTR edge history, and register intr_id=0.
REQ-026 SHALL drive every output to 0 during any cycle in which RST=1, including a reset mid-instruction or mid-wait.
REQ-027 SHALL begin fetching (memRDEN1=1) in the first cycle after RST falls.

Configuration
REQ-028 SHALL compile in interrupt support only when macro CU_FSM_WS_INTR_EN is defined.
REQ-029 SHALL, without CU_FSM_WS_INTR_EN, omit the pending logic and ST_INTR, ignore INTR and mie, and tie int_taken=0 and intr_id=0.

Structure
REQ-030 SHALL take the state enum, opcode constants and the MEM_LAT/N_INTR legal-range constants from shared package cu_fsm_pkg.
REQ-031 SHALL place edge detection, the pending register and the priority encoder in sub-module intr_arb, parametrised by N_INTR.

Verification
REQ-032 SHALL cover: MEM_LAT=1, OP (0110011) -> FETCH 1 cycle, EXEC with regWrite=1 and PCWrite=1, 2 cycles per instruction.
REQ-033 SHALL cover: MEM_LAT=3, LOAD -> memRDEN1 high 3 cycles, memRDEN2 in EXEC, regWrite and PCWrite on the 3rd WB cycle, 7 cycles total.
REQ-034 SHALL cover: N_INTR=4, INTR=4'b1010 edge during a STORE with mie=1 -> ST_INTR with intr_id=1; the next instruction then enters ST_INTR with intr_id=3.
REQ-035 SHALL cover: mie=0 with INTR[0] edge -> no int_taken; after mie is set to 1 -> int_taken at the end of the next instruction.
REQ-036 SHALL cover: RST=1 asserted during the 2nd WB cycle -> all outputs 0, next cycle in ST_FETCH, pending bits cleared.
REQ-037 SHALL cover: SYSTEM with func3=000 -> mret_exec=1 and PCWrite=1; SYSTEM with func3=001 -> csr_WE=1 and regWrite=1.
